// File: rtl/func_vector_sequencer_if.sv
// Stimulus/response bundle between the vector sequencer and the block under test.
// The slave side is the sequencer; the master side issues runs and returns y/z.
interface func_vector_sequencer_if;
  logic       start;
  logic       abort;
  logic       a, b, c, d;
  logic       y, z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_count;
  logic       fail_valid;
  logic [3:0] first_fail_idx;

  modport slave (
    input  start, abort, y, z,
    output a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail_idx
  );

  modport master (
    output start, abort, y, z,
    input  a, b, c, d, busy, done, pass, err_count, fail_valid, first_fail_idx
  );
endinterface

// File: rtl/func_vector_sequencer.sv
// Exhaustive self-check for a 4-input combinational block: sweeps all 16 input
// patterns, holds each HOLD_CYCLES clocks, compares y/z with expected tables.
module func_vector_sequencer #(
  parameter int          HOLD_CYCLES = 4,
  parameter logic [15:0] EXP_Y       = 16'h0000,
  parameter logic [15:0] EXP_Z       = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  func_vector_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  localparam logic [7:0] LAST_HOLD = 8'(HOLD_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] hold_q, hold_d;
  logic [4:0] err_q, err_d;
  logic       fv_q, fv_d;
  logic [3:0] ffi_q, ffi_d;
  logic       pass_q, pass_d;
  logic       mismatch;

  assign mismatch = (bus.y != EXP_Y[idx_q]) || (bus.z != EXP_Z[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      ffi_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      ffi_q   <= ffi_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    err_d   = err_q;
    fv_d    = fv_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous abort here; abort only matters in DRIVE
        if (bus.start) begin
          state_d = DRIVE;
          idx_d   = '0;
          hold_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          ffi_d   = '0;
          pass_d  = 1'b0;
        end
      end
      DRIVE: begin
        if (bus.abort) begin
          state_d = IDLE;
          pass_d  = 1'b0;
        end else if (hold_q == LAST_HOLD) begin
          if (mismatch) begin
            err_d = err_q + 5'd1;
            if (!fv_q) begin
              fv_d  = 1'b1;
              ffi_d = idx_q;
            end
          end
          hold_d = '0;
          if (idx_q == 4'd15) begin
            state_d = DONE;
            pass_d  = (err_d == '0);
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign {bus.a, bus.b, bus.c, bus.d} = (state_q == DRIVE) ? idx_q : 4'd0;
  assign bus.busy           = (state_q == DRIVE);
  assign bus.done           = (state_q == DONE);
  assign bus.pass           = pass_q;
  assign bus.err_count      = err_q;
  assign bus.fail_valid     = fv_q;
  assign bus.first_fail_idx = ffi_q;
endmodule

// File: tb/tb_func_vector_sequencer.sv
// Directed bench for func_vector_sequencer with a behavioural func model that
// can inject faults on chosen patterns.
module tb_func_vector_sequencer;
  localparam logic [15:0] TY = 16'hE8E8;
  localparam logic [15:0] TZ = 16'h6996;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   failures = 0;

  func_vector_sequencer_if bus ();

  func_vector_sequencer #(
    .HOLD_CYCLES(4),
    .EXP_Y      (TY),
    .EXP_Z      (TZ)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // func model: 0 clean, 1 y stuck 0, 2 z wrong on 15, 3 y and z wrong on 5
  logic [3:0] pidx;
  always_comb begin
    pidx  = {bus.a, bus.b, bus.c, bus.d};
    bus.y = TY[pidx];
    bus.z = TZ[pidx];
    if (mode == 1) bus.y = 1'b0;
    if (mode == 2 && pidx == 4'd15) bus.z = ~TZ[pidx];
    if (mode == 3 && pidx == 4'd5) begin
      bus.y = ~TY[pidx];
      bus.z = ~TZ[pidx];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {bus.a, bus.b, bus.c, bus.d, bus.busy, bus.done, bus.pass,
            bus.err_count, bus.fail_valid, bus.first_fail_idx};
  endfunction

  // One run from a start pulse; returns cycle of done (relative to E0) and done count.
  task automatic run(input int m, input int abort_at, input bit poke,
                     output int done_at, output int ndone);
    bit pat_chk;
    pat_chk = (m == 0) && (abort_at == 0) && !poke;
    mode    = m;
    done_at = -1;
    ndone   = 0;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", {31'd0, bus.busy}, 32'd1);
    for (int cy = 1; cy <= 90; cy++) begin
      if (poke && cy == 14) bus.start = 1'b1;
      if (poke && cy == 15) bus.start = 1'b0;
      if (poke && done_at > 0 && cy == done_at + 1) bus.start = 1'b1;
      if (poke && done_at > 0 && cy == done_at + 2) bus.start = 1'b0;
      if (cy == abort_at) bus.abort = 1'b1;
      if (cy == abort_at + 1) bus.abort = 1'b0;
      @(posedge clk); #1;
      if (pat_chk && cy < 64 && cy % 4 == 0)
        chk($sformatf("pattern_%0d", cy / 4), {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'(cy / 4));
      if (abort_at != 0 && cy == abort_at) begin
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_abcd", {28'd0, bus.a, bus.b, bus.c, bus.d}, 32'd0);
        chk("abort_partial", {bus.pass, bus.err_count, bus.fail_valid, bus.first_fail_idx},
            {1'b0, 5'd1, 1'b1, 4'd5});
      end
      if (bus.done) begin
        if (done_at < 0) done_at = cy;
        ndone++;
      end
    end
  endtask

  int dat, nd;

  initial begin
    bus.start = 1'b0;
    bus.abort = 1'b0;
    #1;
    chk("reset_outputs", {16'd0, outs()}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", {16'd0, outs()}, 32'd0);

    // clean sweep
    run(0, 0, 1'b0, dat, nd);
    chk("clean_done_cycle", 32'(dat), 32'd64);
    chk("clean_done_count", 32'(nd), 32'd1);
    chk("clean_result", {bus.pass, bus.err_count, bus.fail_valid}, {1'b1, 5'd0, 1'b0});

    // y stuck at 0: mismatches where TY has ones
    run(1, 0, 1'b0, dat, nd);
    chk("ystuck_done", 32'(nd), 32'd1);
    chk("ystuck_result", {bus.pass, bus.err_count, bus.fail_valid, bus.first_fail_idx},
        {1'b0, 5'd8, 1'b1, 4'd3});

    run(2, 0, 1'b0, dat, nd);
    chk("z15_result", {bus.pass, bus.err_count, bus.fail_valid, bus.first_fail_idx},
        {1'b0, 5'd1, 1'b1, 4'd15});

    run(3, 0, 1'b0, dat, nd);
    chk("yz5_result", {bus.pass, bus.err_count, bus.fail_valid, bus.first_fail_idx},
        {1'b0, 5'd1, 1'b1, 4'd5});

    // start pulses mid-run and in the done cycle are ignored
    run(0, 0, 1'b1, dat, nd);
    chk("poke_done_cycle", 32'(dat), 32'd64);
    chk("poke_done_count", 32'(nd), 32'd1);
    chk("poke_idle_after", {31'd0, bus.busy}, 32'd0);

    // abort during pattern 7 (after the pattern-5 fault has been recorded)
    run(3, 30, 1'b0, dat, nd);
    chk("abort_no_done", 32'(nd), 32'd0);
    chk("abort_idle", {31'd0, bus.busy}, 32'd0);
    run(0, 0, 1'b0, dat, nd);
    chk("post_abort_sweep", {bus.pass, bus.err_count, bus.fail_valid, 5'(nd)},
        {1'b1, 5'd0, 1'b0, 5'd1});

    // start with abort together in IDLE is accepted
    mode = 0;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort_idle", {31'd0, bus.busy}, 32'd1);
    chk("start_clears_pass", {31'd0, bus.pass}, 32'd0);

    // asynchronous reset mid-run with a fault recorded
    mode = 1;
    repeat (20) @(posedge clk);
    #1;
    chk("midrun_busy", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {16'd0, outs()}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("idle_after_release", {16'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
